// File: rtl/pq_op_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : pq_op_scheduler_if
//  Description : Requester, response and queue-side bundle of the priority
//                queue op scheduler (slave = scheduler, master = environment).
//  Revision    : 1.0 - initial release
// ============================================================================
interface pq_op_scheduler_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 16
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]            i_req_valid;
  logic [2*NUM_REQ-1:0]          i_req_op;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic                          o_rsp_valid;
  logic [ID_W-1:0]               o_rsp_id;
  logic [DATA_WIDTH-1:0]         o_rsp_data;
  logic                          o_err;
  logic                          o_pq_wrt;
  logic                          o_pq_read;
  logic [DATA_WIDTH-1:0]         o_pq_data;
  logic                          i_pq_full;
  logic                          i_pq_empty;
  logic [DATA_WIDTH-1:0]         i_pq_data;
  logic [31:0]                   o_stat_issued;
  logic [31:0]                   o_stat_stall;

  modport slave (
    input  i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
    output o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_err,
           o_pq_wrt, o_pq_read, o_pq_data, o_stat_issued, o_stat_stall
  );

  modport master (
    output i_req_valid, i_req_op, i_req_data, i_pq_full, i_pq_empty, i_pq_data,
    input  o_req_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_err,
           o_pq_wrt, o_pq_read, o_pq_data, o_stat_issued, o_stat_stall
  );
endinterface
`default_nettype wire

// File: rtl/pq_op_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : pq_op_scheduler
//  Description : Round-robin arbiter and op sequencer in front of the cycled
//                register-tree priority queue. Optional statistics counters
//                are enabled with macro PQ_SCHED_STATS_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module pq_op_scheduler #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             i_CLK,
  input  logic             i_RSTn,
  pq_op_scheduler_if.slave bus
);

  localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (SETTLE_CYCLES < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);

  localparam logic [1:0] c_OP_ILL = 2'b00;
  localparam logic [1:0] c_OP_ENQ = 2'b01;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_SETTLE = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_W-1:0]      r_settle_cnt;
  logic [CNT_W-1:0]      w_settle_cnt_nxt;
  logic [ID_W-1:0]       r_rr_ptr;
  logic [ID_W-1:0]       w_rr_ptr_nxt;

  logic                  r_rsp_valid;
  logic [ID_W-1:0]       r_rsp_id;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_err;

  logic [1:0]            w_op   [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_key  [NUM_REQ];
  logic [NUM_REQ-1:0]    w_cond;
  logic [NUM_REQ-1:0]    w_elig;

  logic                  w_found;
  logic [ID_W-1:0]       w_win;
  logic [ID_W-1:0]       w_idx;
  logic [1:0]            w_sel_op;
  logic [DATA_WIDTH-1:0] w_sel_key;

  logic [NUM_REQ-1:0]    w_grant;
  logic                  w_wrt;
  logic                  w_read;
  logic [DATA_WIDTH-1:0] w_pq_data;
  logic                  w_issue;
  logic                  w_drop;

  // Queue-flag condition is independent of valid so it can also feed stall stats
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
    assign w_op[g]   = bus.i_req_op[2*g +: 2];
    assign w_key[g]  = bus.i_req_data[g*DATA_WIDTH +: DATA_WIDTH];
    assign w_cond[g] = (w_op[g] == c_OP_ILL) ? 1'b1 :
                       (w_op[g] == c_OP_ENQ) ? ~bus.i_pq_full : ~bus.i_pq_empty;
    assign w_elig[g] = bus.i_req_valid[g] & w_cond[g];
  end

  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_sel_op  = w_op[w_win];
  assign w_sel_key = w_key[w_win];

  // Grants are suppressed while reset is asserted so every output reads 0
  always_comb begin
    w_state_nxt      = r_state;
    w_settle_cnt_nxt = r_settle_cnt;
    w_rr_ptr_nxt     = r_rr_ptr;
    w_grant          = '0;
    w_wrt            = 1'b0;
    w_read           = 1'b0;
    w_pq_data        = '0;
    w_issue          = 1'b0;
    w_drop           = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && i_RSTn) begin
          w_grant[w_win] = 1'b1;
          w_rr_ptr_nxt   = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);
          if (w_sel_op == c_OP_ILL || (w_sel_op == c_OP_ENQ && w_sel_key == '0)) begin
            w_drop = 1'b1;
          end else begin
            w_issue = 1'b1;
            w_wrt   = w_sel_op[0];
            w_read  = w_sel_op[1];
            if (w_sel_op[0]) begin
              w_pq_data = w_sel_key;
            end
            if (SETTLE_CYCLES > 0) begin
              w_state_nxt      = ST_SETTLE;
              w_settle_cnt_nxt = CNT_W'(SETTLE_CYCLES);
            end
          end
        end
      end
      ST_SETTLE: begin
        if (r_settle_cnt <= CNT_W'(1)) begin
          w_state_nxt      = ST_IDLE;
          w_settle_cnt_nxt = '0;
        end else begin
          w_settle_cnt_nxt = r_settle_cnt - CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_settle_cnt_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_rr_ptr     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_cnt_nxt;
      r_rr_ptr     <= w_rr_ptr_nxt;
    end
  end

  // Root is captured in the grant cycle, before the queue reacts to the strobe
  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= '0;
      r_rsp_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_rsp_valid <= w_issue & w_read;
      r_err       <= w_drop;
      if (w_issue && w_read) begin
        r_rsp_id   <= w_win;
        r_rsp_data <= bus.i_pq_data;
      end
    end
  end

  assign bus.o_req_ready = w_grant;
  assign bus.o_pq_wrt    = w_wrt;
  assign bus.o_pq_read   = w_read;
  assign bus.o_pq_data   = w_pq_data;
  assign bus.o_rsp_valid = r_rsp_valid;
  assign bus.o_rsp_id    = r_rsp_id;
  assign bus.o_rsp_data  = r_rsp_data;
  assign bus.o_err       = r_err;

`ifdef PQ_SCHED_STATS_EN
  logic [NUM_REQ-1:0] w_blocked;
  logic               w_stall;
  logic [31:0]        r_stat_issued;
  logic [31:0]        r_stat_stall;

  assign w_blocked = bus.i_req_valid & ~w_cond;
  assign w_stall   = (r_state == ST_IDLE) && (|w_blocked);

  always_ff @(posedge i_CLK or negedge i_RSTn) begin
    if (!i_RSTn) begin
      r_stat_issued <= '0;
      r_stat_stall  <= '0;
    end else begin
      if (w_issue && r_stat_issued != '1) begin
        r_stat_issued <= r_stat_issued + 32'd1;
      end
      if (w_stall && r_stat_stall != '1) begin
        r_stat_stall <= r_stat_stall + 32'd1;
      end
    end
  end

  assign bus.o_stat_issued = r_stat_issued;
  assign bus.o_stat_stall  = r_stat_stall;
`else
  assign bus.o_stat_issued = '0;
  assign bus.o_stat_stall  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pq_op_scheduler.sv
`default_nettype none
// Randomized bench for pq_op_scheduler: random requesters and queue flags,
// checked cycle by cycle against a transaction-level reference model.
module tb_pq_op_scheduler;
  localparam int NUM_REQ = 4;
  localparam int DW      = 16;
  localparam int SETTLE  = 4;
  localparam int NCYC    = 3000;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  pq_op_scheduler_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DW)) bus ();

  pq_op_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .DATA_WIDTH   (DW),
    .SETTLE_CYCLES(SETTLE)
  ) dut (
    .i_CLK (clk),
    .i_RSTn(rstn),
    .bus   (bus.slave)
  );

  int n_total = 0;
  int n_bad   = 0;

  // requester state (held stable until granted)
  bit          pend [NUM_REQ];
  logic [1:0]  rop  [NUM_REQ];
  logic [DW-1:0] rkey [NUM_REQ];
  bit          q_full, q_empty;
  logic [DW-1:0] q_root;

  // reference model state
  int          ptr;
  int          busy_left;
  bit          exp_rsp_valid;
  int          exp_rsp_id;
  logic [DW-1:0] exp_rsp_data;
  bit          exp_err;
  longint      stat_issued, stat_stall;
  int          granted;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic bit eligible(input logic [1:0] op, input bit full, input bit empty);
    if (op == 2'b00) return 1'b1;
    if (op == 2'b01) return !full;
    return !empty;
  endfunction

  task automatic apply();
    logic [NUM_REQ-1:0]    v;
    logic [2*NUM_REQ-1:0]  o;
    logic [NUM_REQ*DW-1:0] d;
    for (int i = 0; i < NUM_REQ; i++) begin
      v[i]          = pend[i];
      o[2*i +: 2]   = rop[i];
      d[i*DW +: DW] = rkey[i];
    end
    bus.i_req_valid = v;
    bus.i_req_op    = o;
    bus.i_req_data  = d;
    bus.i_pq_full   = q_full;
    bus.i_pq_empty  = q_empty;
    bus.i_pq_data   = q_root;
  endtask

  task automatic model_reset();
    ptr = 0; busy_left = 0; exp_rsp_valid = 0; exp_rsp_id = 0;
    exp_rsp_data = '0; exp_err = 0; stat_issued = 0; stat_stall = 0; granted = -1;
  endtask

  task automatic new_stimulus();
    int r;
    if (granted >= 0) pend[granted] = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!pend[i] && $urandom_range(0, 99) < 40) begin
        pend[i] = 1'b1;
        r = $urandom_range(0, 19);
        rop[i]  = (r == 0) ? 2'b00 : (r < 9) ? 2'b01 : (r < 15) ? 2'b10 : 2'b11;
        rkey[i] = ($urandom_range(0, 9) == 0) ? '0 : DW'($urandom);
      end
    end
    q_full  = ($urandom_range(0, 99) < 20);
    q_empty = !q_full && ($urandom_range(0, 99) < 30);
    q_root  = DW'($urandom);
    apply();
  endtask

  // Compare one cycle's outputs with the model, then advance the model
  task automatic check_cycle();
    int g = -1;
    int idx;
    bit drop = 0, blocked = 0;
    logic [NUM_REQ-1:0] e_ready = '0;
    bit e_wrt = 0, e_read = 0;
    logic [DW-1:0] e_data = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pend[i] && !eligible(rop[i], q_full, q_empty)) blocked = 1;
    if (busy_left == 0) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (ptr + k) % NUM_REQ;
        if (g < 0 && pend[idx] && eligible(rop[idx], q_full, q_empty)) g = idx;
      end
    end
    if (g >= 0) begin
      e_ready[g] = 1'b1;
      drop = (rop[g] == 2'b00) || (rop[g] == 2'b01 && rkey[g] == '0);
      if (!drop) begin
        e_wrt  = (rop[g] == 2'b01) || (rop[g] == 2'b11);
        e_read = (rop[g] == 2'b10) || (rop[g] == 2'b11);
        e_data = rkey[g];
      end
    end
    chk("req_ready", 64'(bus.o_req_ready), 64'(e_ready));
    chk("pq_wrt",    64'(bus.o_pq_wrt),    64'(e_wrt));
    chk("pq_read",   64'(bus.o_pq_read),   64'(e_read));
    if (e_wrt) chk("pq_data", 64'(bus.o_pq_data), 64'(e_data));
    chk("rsp_valid", 64'(bus.o_rsp_valid), 64'(exp_rsp_valid));
    if (exp_rsp_valid) begin
      chk("rsp_id",   64'(bus.o_rsp_id),   64'(exp_rsp_id));
      chk("rsp_data", 64'(bus.o_rsp_data), 64'(exp_rsp_data));
    end
    chk("err", 64'(bus.o_err), 64'(exp_err));
`ifdef PQ_SCHED_STATS_EN
    chk("stat_issued", 64'(bus.o_stat_issued), 64'(stat_issued));
    chk("stat_stall",  64'(bus.o_stat_stall),  64'(stat_stall));
    if (g >= 0 && !drop) stat_issued++;
    if (busy_left == 0 && blocked) stat_stall++;
`else
    chk("stat_issued", 64'(bus.o_stat_issued), 64'd0);
    chk("stat_stall",  64'(bus.o_stat_stall),  64'd0);
    if (blocked) stat_stall++;
`endif
    exp_rsp_valid = (g >= 0) && !drop && e_read;
    if (exp_rsp_valid) begin
      exp_rsp_id   = g;
      exp_rsp_data = q_root;
    end
    exp_err = (g >= 0) && drop;
    if (busy_left > 0) busy_left--;
    else if (g >= 0 && !drop) busy_left = SETTLE;
    if (g >= 0) ptr = (g + 1) % NUM_REQ;
    granted = g;
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    new_stimulus();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"},     64'(bus.o_req_ready), 64'd0);
    chk({tag, "_wrt"},       64'(bus.o_pq_wrt),    64'd0);
    chk({tag, "_read"},      64'(bus.o_pq_read),   64'd0);
    chk({tag, "_rsp_valid"}, 64'(bus.o_rsp_valid), 64'd0);
    chk({tag, "_err"},       64'(bus.o_err),       64'd0);
    chk({tag, "_stat"},      64'(bus.o_stat_issued), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int tries;
    model_reset();
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b1; rop[i] = 2'b01; rkey[i] = DW'(i + 5);
    end
    q_full = 0; q_empty = 1; q_root = '0;
    apply();
    #2;
    chk_all_zero("reset");
    @(posedge clk);
    #2;
    chk_all_zero("reset_edge");
    rstn = 1'b1;

    for (int c = 0; c < NCYC; c++) step();

    // Reset in the second settle cycle, with a request waiting
    tries = 0;
    while (busy_left != SETTLE && tries < 300) begin
      step();
      tries++;
    end
    chk("reach_settle", 64'(busy_left), 64'(SETTLE));
    step();
    pend[2] = 1'b1; rop[2] = 2'b01; rkey[2] = 16'h0042; q_full = 0;
    apply();
    rstn = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    model_reset();
    @(posedge clk);
    #2;
    chk_all_zero("mid_rst_edge");
    rstn = 1'b1;
    step();
    chk("post_rst_grant_seen", 64'(granted >= 0), 64'd1);
    for (int c = 0; c < 200; c++) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
